// File: rtl/fq_pkg.sv
// Shared defaults and FSM state types for the free-pointer queue arbiter.
package fq_pkg;

    localparam int unsigned DEF_NUM_PORTS   = 4;
    localparam int unsigned DEF_PTR_W       = 9;
    localparam int unsigned DEF_INIT_CYCLES = 528;
    localparam int unsigned DEF_FREE_INIT   = 511;

    typedef enum logic [1:0] {
        A_IDLE,
        A_POP,
        A_GAP
    } alloc_state_e;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rel_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at ptr_q; ptr moves past the winner only when advance_i is set.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fq_ptr_arbiter.sv
// Shares the free-pointer FIFO among requesters: RR alloc (pop) and release (push) sides,
// gated by the pool init window, with free-pointer tracking and a sticky over-release flag.
module fq_ptr_arbiter
    import fq_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = DEF_NUM_PORTS,
    parameter int unsigned PTR_W       = DEF_PTR_W,
    parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int unsigned FREE_INIT   = DEF_FREE_INIT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS-1:0]       alloc_req,
    output logic [NUM_PORTS-1:0]       alloc_gnt,
    output logic [PTR_W-1:0]           alloc_ptr,
    input  logic [NUM_PORTS-1:0]       rel_req,
    input  logic [NUM_PORTS*PTR_W-1:0] rel_ptr,
    output logic [NUM_PORTS-1:0]       rel_ack,
    output logic                       fq_rd,
    input  logic [PTR_W-1:0]           fq_ptr_dout,
    input  logic                       fq_empty,
    output logic                       fq_wr,
    output logic [PTR_W-1:0]           fq_ptr_din,
    output logic                       ready,
    output logic [PTR_W:0]             free_cnt,
    output logic                       err_overflow
);

    localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    alloc_state_e         a_state_q, a_state_d;
    rel_state_e           r_state_q, r_state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic                 ready_q, ready_d, init_done;
    logic [IDX_W-1:0]     a_win_q, a_win_d;
    logic [NUM_PORTS-1:0] alloc_gnt_q, alloc_gnt_d;
    logic [PTR_W-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic                 fq_rd_q, fq_rd_d;
    logic [NUM_PORTS-1:0] rel_ack_q, rel_ack_d;
    logic                 fq_wr_q, fq_wr_d;
    logic [PTR_W-1:0]     fq_ptr_din_q, fq_ptr_din_d;
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] a_gnt, r_gnt;
    logic [IDX_W-1:0]     a_idx, r_idx;
    logic                 a_adv, r_adv;
    logic [PTR_W-1:0]     rel_sel;

    rr_arbiter #(.N(NUM_PORTS)) u_alloc_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (alloc_req),
        .advance_i(a_adv),
        .gnt_o    (a_gnt),
        .idx_o    (a_idx)
    );

    rr_arbiter #(.N(NUM_PORTS)) u_rel_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (rel_req),
        .advance_i(r_adv),
        .gnt_o    (r_gnt),
        .idx_o    (r_idx)
    );

    always_comb begin
        init_done  = (init_cnt_q == INIT_W'(INIT_CYCLES - 1));
        ready_d    = ready_q | init_done;
        init_cnt_d = (ready_q || init_done) ? init_cnt_q : init_cnt_q + INIT_W'(1);
    end

    always_comb begin
        a_state_d   = a_state_q;
        a_win_d     = a_win_q;
        a_adv       = 1'b0;
        fq_rd_d     = 1'b0;
        alloc_gnt_d = '0;
        alloc_ptr_d = alloc_ptr_q;
        case (a_state_q)
            A_IDLE: begin
                if (ready_q && !fq_empty && (|a_gnt)) begin
                    a_win_d   = a_idx;
                    a_adv     = 1'b1;
                    fq_rd_d   = 1'b1;
                    a_state_d = A_POP;
                end
            end
            A_POP: begin
                alloc_ptr_d = fq_ptr_dout;
                alloc_gnt_d = NUM_PORTS'(1) << a_win_q;
                a_state_d   = A_GAP;
            end
            A_GAP:   a_state_d = A_IDLE;
            default: a_state_d = A_IDLE;
        endcase
    end

    always_comb begin
        rel_sel = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                rel_sel = rel_ptr[k*PTR_W +: PTR_W];
            end
        end
    end

    // A full pool still acks the requester so it never stalls; only the push is dropped.
    always_comb begin
        r_state_d    = r_state_q;
        r_adv        = 1'b0;
        rel_ack_d    = '0;
        fq_wr_d      = 1'b0;
        fq_ptr_din_d = fq_ptr_din_q;
        err_d        = err_q;
        case (r_state_q)
            R_IDLE: begin
                if (ready_q && (|r_gnt)) begin
                    r_adv        = 1'b1;
                    rel_ack_d    = r_gnt;
                    fq_ptr_din_d = rel_sel;
                    if (free_cnt_q == CNT_W'(FREE_INIT)) begin
                        err_d = 1'b1;
                    end else begin
                        fq_wr_d = 1'b1;
                    end
                    r_state_d = R_ACK;
                end
            end
            R_ACK:   r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        free_cnt_d = free_cnt_q;
        if (!ready_q) begin
            if (init_done) begin
                free_cnt_d = CNT_W'(FREE_INIT);
            end
        end else begin
            case ({a_state_q == A_POP, fq_wr_q})
                2'b10:   free_cnt_d = free_cnt_q - CNT_W'(1);
                2'b01:   free_cnt_d = free_cnt_q + CNT_W'(1);
                default: free_cnt_d = free_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_state_q    <= A_IDLE;
            r_state_q    <= R_IDLE;
            init_cnt_q   <= '0;
            ready_q      <= 1'b0;
            a_win_q      <= '0;
            alloc_gnt_q  <= '0;
            alloc_ptr_q  <= '0;
            fq_rd_q      <= 1'b0;
            rel_ack_q    <= '0;
            fq_wr_q      <= 1'b0;
            fq_ptr_din_q <= '0;
            free_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            a_state_q    <= a_state_d;
            r_state_q    <= r_state_d;
            init_cnt_q   <= init_cnt_d;
            ready_q      <= ready_d;
            a_win_q      <= a_win_d;
            alloc_gnt_q  <= alloc_gnt_d;
            alloc_ptr_q  <= alloc_ptr_d;
            fq_rd_q      <= fq_rd_d;
            rel_ack_q    <= rel_ack_d;
            fq_wr_q      <= fq_wr_d;
            fq_ptr_din_q <= fq_ptr_din_d;
            free_cnt_q   <= free_cnt_d;
            err_q        <= err_d;
        end
    end

    assign alloc_gnt    = alloc_gnt_q;
    assign alloc_ptr    = alloc_ptr_q;
    assign fq_rd        = fq_rd_q;
    assign rel_ack      = rel_ack_q;
    assign fq_wr        = fq_wr_q;
    assign fq_ptr_din   = fq_ptr_din_q;
    assign ready        = ready_q;
    assign free_cnt     = free_cnt_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_fq_ptr_arbiter.sv
// Bench for fq_ptr_arbiter: FWFT pool model plus grant/ack scoreboards checked every cycle.
module tb_fq_ptr_arbiter;

    localparam int INIT = 528;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  alloc_req;
    logic [3:0]  alloc_gnt;
    logic [8:0]  alloc_ptr;
    logic [3:0]  rel_req;
    logic [35:0] rel_ptr;
    logic [3:0]  rel_ack;
    logic        fq_rd;
    logic [8:0]  fq_ptr_dout;
    logic        fq_empty;
    logic        fq_wr;
    logic [8:0]  fq_ptr_din;
    logic        ready;
    logic [9:0]  free_cnt;
    logic        err_overflow;

    fq_ptr_arbiter #(
        .NUM_PORTS  (4),
        .PTR_W      (9),
        .INIT_CYCLES(528),
        .FREE_INIT  (511)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_ptr   (alloc_ptr),
        .rel_req     (rel_req),
        .rel_ptr     (rel_ptr),
        .rel_ack     (rel_ack),
        .fq_rd       (fq_rd),
        .fq_ptr_dout (fq_ptr_dout),
        .fq_empty    (fq_empty),
        .fq_wr       (fq_wr),
        .fq_ptr_din  (fq_ptr_din),
        .ready       (ready),
        .free_cnt    (free_cnt),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // FWFT pool model, refilled with 0..510 on reset
    logic [8:0] pool [512];
    logic [9:0] rd_p, wr_p;
    logic       force_empty;

    assign fq_ptr_dout = pool[rd_p[8:0]];
    assign fq_empty    = force_empty || (rd_p == wr_p);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) pool[i] <= 9'(i);
            rd_p <= '0;
            wr_p <= 10'd511;
        end else begin
            if (fq_rd) rd_p <= rd_p + 10'd1;
            if (fq_wr) begin
                pool[wr_p[8:0]] <= fq_ptr_din;
                wr_p <= wr_p + 10'd1;
            end
        end
    end

    typedef struct {
        logic [3:0] gnt;
        logic [8:0] ptr;
        int         cyc;
    } a_exp_t;

    typedef struct {
        logic [3:0] ack;
        logic       wr;
        logic [8:0] din;
        int         cyc;
    } r_exp_t;

    a_exp_t exp_a[$];
    r_exp_t exp_r[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_rd = -1;

    task automatic push_a(input logic [3:0] g, input logic [8:0] p, input int c);
        a_exp_t e;
        e.gnt = g; e.ptr = p; e.cyc = c;
        exp_a.push_back(e);
    endtask

    task automatic push_r(input logic [3:0] a, input logic w, input logic [8:0] d, input int c);
        r_exp_t e;
        e.ack = a; e.wr = w; e.din = d; e.cyc = c;
        exp_r.push_back(e);
    endtask

    // One clock step; scoreboards retire grants/acks, requesters drop a served request.
    task automatic tick();
        a_exp_t ea;
        r_exp_t er;
        @(posedge clk);
        #1;
        cyc++;
        if (fq_rd === 1'b1 && first_rd < 0) first_rd = cyc;
        if (alloc_gnt !== 4'b0000) begin
            n_checks++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL alloc_unexpected: gnt=%b ptr=%0d at cycle %0d, no grant expected",
                         alloc_gnt, alloc_ptr, cyc);
            end else begin
                ea = exp_a.pop_front();
                if (alloc_gnt !== ea.gnt || alloc_ptr !== ea.ptr || cyc != ea.cyc) begin
                    n_fail++;
                    $display("FAIL alloc_grant: got gnt=%b ptr=%0d cyc=%0d, expected gnt=%b ptr=%0d cyc=%0d",
                             alloc_gnt, alloc_ptr, cyc, ea.gnt, ea.ptr, ea.cyc);
                end
            end
            alloc_req = alloc_req & ~alloc_gnt;
        end else if (exp_a.size() != 0 && exp_a[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL alloc_missing: no grant at cycle %0d, expected gnt=%b ptr=%0d",
                     exp_a[0].cyc, exp_a[0].gnt, exp_a[0].ptr);
            void'(exp_a.pop_front());
        end
        if (rel_ack !== 4'b0000) begin
            n_checks++;
            if (exp_r.size() == 0) begin
                n_fail++;
                $display("FAIL rel_unexpected: ack=%b wr=%b din=%0h at cycle %0d, no ack expected",
                         rel_ack, fq_wr, fq_ptr_din, cyc);
            end else begin
                er = exp_r.pop_front();
                if (rel_ack !== er.ack || fq_wr !== er.wr || (er.wr && fq_ptr_din !== er.din) ||
                    cyc != er.cyc) begin
                    n_fail++;
                    $display("FAIL rel_ack: got ack=%b wr=%b din=%0h cyc=%0d, expected ack=%b wr=%b din=%0h cyc=%0d",
                             rel_ack, fq_wr, fq_ptr_din, cyc, er.ack, er.wr, er.din, er.cyc);
                end
            end
            rel_req = rel_req & ~rel_ack;
        end else if (exp_r.size() != 0 && exp_r[0].cyc < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL rel_missing: no ack at cycle %0d, expected ack=%b", exp_r[0].cyc, exp_r[0].ack);
            void'(exp_r.pop_front());
        end
        if (ready === 1'b1) begin
            n_checks++;
            if (free_cnt !== (wr_p - rd_p)) begin
                n_fail++;
                $display("FAIL free_cnt_model: got %0d, pool holds %0d at cycle %0d",
                         free_cnt, wr_p - rd_p, cyc);
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        alloc_req   = '0;
        rel_req     = '0;
        rel_ptr     = '0;
        force_empty = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Reset was just released: ready must stay low for cycles 1..INIT-1 and rise in cycle INIT.
    task automatic wait_ready();
        int early = 0;
        for (int n = 1; n < INIT; n++) begin
            tick();
            if (ready !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL ready_early: ready high in %0d cycles, required 0", early);
        end
        tick();
        n_checks++;
        if (ready !== 1'b1 || free_cnt !== 10'd511) begin
            n_fail++;
            $display("FAIL ready_rise: ready=%b free_cnt=%0d, required ready=1 free_cnt=511", ready, free_cnt);
        end
    endtask

    task automatic test_reset();
        int rc;
        reset       = 1'b1;
        alloc_req   = '0;
        rel_req     = '0;
        rel_ptr     = '0;
        force_empty = 1'b0;
        tick();
        n_checks++;
        if ({alloc_gnt, alloc_ptr, rel_ack, fq_rd, fq_wr, fq_ptr_din, ready, free_cnt, err_overflow} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b ptr=%0d ack=%b rd=%b wr=%b rdy=%b cnt=%0d err=%b, required all 0",
                     alloc_gnt, alloc_ptr, rel_ack, fq_rd, fq_wr, ready, free_cnt, err_overflow);
        end
        tick();
        reset     = 1'b0;
        alloc_req = 4'b0001;
        first_rd  = -1;
        wait_ready();
        n_checks++;
        if (first_rd != -1) begin
            n_fail++;
            $display("FAIL rd_before_ready: fq_rd at cycle %0d, required none before ready", first_rd);
        end
        rc = cyc;
        push_a(4'b0001, 9'd0, rc + 2);
        tick();
        n_checks++;
        if (first_rd != rc + 1) begin
            n_fail++;
            $display("FAIL first_pop: fq_rd first at cycle %0d, required %0d", first_rd, rc + 1);
        end
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        wait_ready();
        alloc_req = 4'b1111;
        c = cyc;
        for (int k = 0; k < 4; k++) push_a(4'b0001 << k, 9'(k), c + 2 + 3 * k);
        repeat (14) tick();
        n_checks++;
        if (free_cnt !== 10'd507 || alloc_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_final: free_cnt=%0d req_left=%b, required 507 and 0000", free_cnt, alloc_req);
        end
    endtask

    task automatic test_empty_hold();
        force_empty = 1'b1;
        alloc_req   = 4'b0010;
        first_rd    = -1;
        repeat (6) tick();
        n_checks++;
        if (first_rd != -1) begin
            n_fail++;
            $display("FAIL pop_while_empty: fq_rd at cycle %0d, required none", first_rd);
        end
        force_empty = 1'b0;
        push_a(4'b0010, 9'd4, cyc + 2);
        repeat (4) tick();
        n_checks++;
        if (alloc_req !== 4'b0000 || free_cnt !== 10'd506) begin
            n_fail++;
            $display("FAIL empty_release: req_left=%b free_cnt=%0d, required 0000 and 506", alloc_req, free_cnt);
        end
    endtask

    task automatic test_release();
        int c;
        rel_ptr        = '0;
        rel_ptr[8:0]   = 9'h00A;
        rel_ptr[26:18] = 9'h01C;
        rel_req        = 4'b0101;
        c = cyc;
        push_r(4'b0001, 1'b1, 9'h00A, c + 1);
        push_r(4'b0100, 1'b1, 9'h01C, c + 3);
        repeat (5) tick();
        n_checks++;
        if (free_cnt !== 10'd508 || rel_req !== 4'b0000) begin
            n_fail++;
            $display("FAIL release_final: free_cnt=%0d req_left=%b, required 508 and 0000", free_cnt, rel_req);
        end
    endtask

    task automatic test_concurrent();
        int c;
        rel_ptr[17:9] = 9'h033;
        alloc_req     = 4'b0100;
        rel_req       = 4'b0010;
        c = cyc;
        push_a(4'b0100, 9'd5, c + 2);
        push_r(4'b0010, 1'b1, 9'h033, c + 1);
        tick();
        n_checks++;
        if ({fq_rd, fq_wr} !== 2'b11) begin
            n_fail++;
            $display("FAIL concurrent_strobes: rd=%b wr=%b, required both 1", fq_rd, fq_wr);
        end
        tick();
        n_checks++;
        if (free_cnt !== 10'd508) begin
            n_fail++;
            $display("FAIL concurrent_count: free_cnt=%0d, required 508", free_cnt);
        end
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        do_reset();
        wait_ready();
        rel_ptr[35:27] = 9'h1FF;
        rel_req        = 4'b1000;
        push_r(4'b1000, 1'b0, 9'h000, cyc + 1);
        tick();
        n_checks++;
        if (err_overflow !== 1'b1 || fq_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_flag: err=%b wr=%b, required err=1 wr=0", err_overflow, fq_wr);
        end
        repeat (3) tick();
        n_checks++;
        if (err_overflow !== 1'b1 || free_cnt !== 10'd511) begin
            n_fail++;
            $display("FAIL overflow_sticky: err=%b free_cnt=%0d, required err=1 free_cnt=511", err_overflow, free_cnt);
        end
    endtask

    task automatic test_reset_mid();
        alloc_req = 4'b0001;
        tick();
        n_checks++;
        if (fq_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pop: fq_rd=%b, required 1", fq_rd);
        end
        reset     = 1'b1;
        alloc_req = '0;
        tick();
        n_checks++;
        if ({alloc_gnt, alloc_ptr, rel_ack, fq_rd, fq_wr, fq_ptr_din, ready, free_cnt, err_overflow} !== 40'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: gnt=%b ptr=%0d ack=%b rd=%b wr=%b din=%0h rdy=%b cnt=%0d err=%b, required all 0",
                     alloc_gnt, alloc_ptr, rel_ack, fq_rd, fq_wr, fq_ptr_din, ready, free_cnt, err_overflow);
        end
        reset    = 1'b0;
        first_rd = -1;
        wait_ready();
        n_checks++;
        if (first_rd != -1) begin
            n_fail++;
            $display("FAIL mid_reset_pop: fq_rd at cycle %0d after reset, required none", first_rd);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_empty_hold();
        test_release();
        test_concurrent();
        test_overflow();
        test_reset_mid();
        repeat (3) tick();
        n_checks++;
        if (exp_a.size() != 0 || exp_r.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d grants and %0d acks outstanding, required 0 and 0",
                     exp_a.size(), exp_r.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
